// File: rtl/burst_address_sequencer.sv
// Burst address sequencer: latches one SDRAM burst request, presents each beat address
// and steps it through the external combinational address core until the burst ends.
module burst_address_sequencer (
    input  logic       Clk,
    input  logic       RstN,
    input  logic       Start,
    input  logic [7:0] StartAddr,
    input  logic [2:0] SizeIn,
    input  logic       AddrMode,
    input  logic [2:0] BurstLengthConfig,
    input  logic       Ready,
    input  logic       Abort,
    output logic [7:0] AddrOut,
    output logic       AddrValid,
    output logic       Busy,
    output logic       BurstDone,
    output logic [7:0] CoreAddrIn,
    output logic [2:0] CoreSize,
    output logic       CoreMode,
    output logic [2:0] CoreBurstLength,
    input  logic [7:0] CoreAddrOut
);

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } stateT;

    stateT      state;
    stateT      nextState;

    logic [7:0] addrReg;
    logic [7:0] beatCnt;
    logic [2:0] sizeReg;
    logic       modeReg;
    logic [2:0] blReg;

    logic       startAcc;
    logic       beatAcc;
    logic       lastBeat;
    logic       loadBurst;
    logic       advance;
    logic       validNext;
    logic       doneNext;

    // Remaining beats minus one for each burst-length code; code 7 is a full page.
    function automatic logic [7:0] beatsMinusOne(input logic [2:0] code);
        logic [7:0] cnt;
        case (code)
            3'd0:    cnt = 8'd0;
            3'd1:    cnt = 8'd1;
            3'd2:    cnt = 8'd3;
            3'd3:    cnt = 8'd7;
            3'd4:    cnt = 8'd15;
            3'd5:    cnt = 8'd31;
            3'd6:    cnt = 8'd63;
            default: cnt = 8'd255;
        endcase
        return cnt;
    endfunction

    // Abort takes priority over both a new request and a beat accepted in the same cycle.
    assign startAcc = (state == StIdle) && Start && !Abort;
    assign beatAcc  = (state == StActive) && Ready && !Abort;
    assign lastBeat = beatAcc && (beatCnt == 8'd0);

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            StIdle: begin
                if (startAcc) begin
                    nextState = StActive;
                end
            end
            StActive: begin
                if (Abort || lastBeat) begin
                    nextState = StIdle;
                end
            end
            default: nextState = StIdle;
        endcase
    end

    always_comb begin
        loadBurst = 1'b0;
        advance   = 1'b0;
        validNext = 1'b0;
        doneNext  = 1'b0;
        case (state)
            StIdle: begin
                loadBurst = startAcc;
                validNext = startAcc;
            end
            StActive: begin
                advance   = beatAcc && (beatCnt != 8'd0);
                validNext = !Abort && !lastBeat;
                doneNext  = lastBeat;
            end
            default: ;
        endcase
    end

    // Status outputs are registered from the decoded next state so they never glitch.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            addrReg   <= 8'd0;
            beatCnt   <= 8'd0;
            sizeReg   <= 3'd0;
            modeReg   <= 1'b0;
            blReg     <= 3'd0;
            AddrValid <= 1'b0;
            Busy      <= 1'b0;
            BurstDone <= 1'b0;
        end else begin
            if (loadBurst) begin
                addrReg <= StartAddr;
                beatCnt <= beatsMinusOne(BurstLengthConfig);
                sizeReg <= SizeIn;
                modeReg <= AddrMode;
                blReg   <= BurstLengthConfig;
            end else if (advance) begin
                addrReg <= CoreAddrOut;
                beatCnt <= beatCnt - 8'd1;
            end
            AddrValid <= validNext;
            Busy      <= validNext;
            BurstDone <= doneNext;
        end
    end

    // The core sees only latched configuration, so input changes mid-burst are harmless.
    assign AddrOut         = addrReg;
    assign CoreAddrIn      = addrReg;
    assign CoreSize        = sizeReg;
    assign CoreMode        = modeReg;
    assign CoreBurstLength = blReg;

endmodule

// File: doc/burst_address_sequencer.md
# burst_address_sequencer

Sequential control stage that drives the combinational address generator core for one SDRAM burst. Latches a burst request (start address, increment size, address mode, burst-length code), presents the current beat address to the bus interface, and on each accepted beat loads the core's computed next address. Counts beats down to burst end, pulses completion and returns to idle. The core is instantiated beside this block, not inside it; this block owns the address register and the loop through the core.

## Interface
Parameters: none (address width fixed at 8, size 3, burst code 3).

Ports (name, direction, width, meaning):
- Clk  in  1  system clock, all state on rising edge
- RstN  in  1  reset, synchronous, active-low
- Start  in  1  burst request; sampled only in IDLE
- StartAddr  in  8  first beat address
- SizeIn  in  3  per-beat increment
- AddrMode  in  1  0 = sequential (wrapping), 1 = linear
- BurstLengthConfig  in  3  000=1, 001=2, 010=4, 011=8, 100=16, 101=32, 110=64, 111=page (256 beats)
- Ready  in  1  downstream accepts current address this cycle
- Abort  in  1  terminate the burst at once
- AddrOut  out  8  current beat address
- AddrValid  out  1  AddrOut is valid
- Busy  out  1  burst in progress
- BurstDone  out  1  one-cycle pulse after last beat accepted
- CoreAddrIn  out  8  to core AddrIn (equals AddrOut)
- CoreSize  out  3  to core SizeIn (latched)
- CoreMode  out  1  to core AddrMode (latched)
- CoreBurstLength  out  3  to core BurstLengthConfig (latched)
- CoreAddrOut  in  8  next address from core, combinational

## Operation
- States: IDLE, ACTIVE.
- Registers: Addr[7:0], BeatCnt[7:0] (remaining beats minus 1), latched SizeReg, ModeReg, BlReg.
- IDLE: AddrValid=0, Busy=0. On Start=1 (and Abort=0): Addr<=StartAddr, latch SizeIn/AddrMode/BurstLengthConfig, BeatCnt<=2^code-1 (page: 255), go ACTIVE.
- ACTIVE: AddrValid=1, Busy=1, AddrOut=Addr. Beat accepted when Ready=1.
  - Accepted, BeatCnt!=0: Addr<=CoreAddrOut, BeatCnt<=BeatCnt-1, stay.
  - Accepted, BeatCnt==0: go IDLE, BurstDone=1 next cycle.
  - Not accepted: hold Addr, BeatCnt.
- Abort=1 in ACTIVE: go IDLE next edge, no BurstDone, no further beat counted even if Ready=1 same cycle. Abort in IDLE ignored; Abort wins over Start.
- Start while ACTIVE ignored; no queuing.
- Input config changes during ACTIVE have no effect; core is fed only latched values.
- Address arithmetic is modulo 256 and wrap rules belong entirely to the core; this block copies CoreAddrOut unmodified. SizeIn=0 legal: same address every beat.
- Core* outputs driven continuously from registers, also in IDLE (last latched values; zero after reset).

## Timing
- Reset (RstN=0 at edge): state IDLE, Addr=0, BeatCnt=0, latched config=0; AddrOut=0, AddrValid=0, Busy=0, BurstDone=0. Reset mid-burst abandons it with no BurstDone.
- Start sampled at edge N -> AddrValid=1 with StartAddr from edge N+1.
- With Ready held 1, one beat per cycle; burst of L beats occupies cycles N+1..N+L; BurstDone high for cycle N+L+1 only, AddrValid=0 then.
- Earliest next Start accepted at edge N+L+1 (while BurstDone high); back-to-back bursts leave one idle cycle.
- Ready stalls insert cycles with AddrOut stable.
- BurstDone, AddrValid, Busy are registered outputs; only CoreAddrIn path to core is combinational via register.

## Test plan
- Reset: assert RstN=0 mid page burst -> next cycle AddrValid=0, Busy=0, AddrOut=0, no BurstDone.
- Sequential wrap: StartAddr=0x0E, SizeIn=1, mode 0, code 010, Ready=1 -> AddrOut 0x0E,0x0F,0x0C,0x0D, BurstDone one cycle later.
- Linear: same but mode 1 -> 0x0E,0x0F,0x10,0x11; single-beat code 000 from 0x40 -> one beat 0x40 then BurstDone.
- Stalls: code 011, SizeIn=2, linear from 0x00, Ready toggled 1,0,0,1... -> 8 beats 0x00..0x0E step 2, address held across stalls, total cycles = 8 + stall count.
- Abort and config change: start code 011, after beat 3 change SizeIn/mode (no effect), then Abort with Ready=1 -> IDLE next cycle, no BurstDone, Start in same cycle ignored.
- Page: code 111, linear, SizeIn=1 from 0xFF -> 256 beats 0xFF,0x00,...,0xFE, BurstDone after beat 256.
